// File: rtl/parallel_serial_gen.sv
// parallel_serial_gen
//   PHY-TX serializer. WIDTH-bit parallel words enter through a valid/ready
//   handshake into a one-word holding buffer. They are shifted out one bit per
//   clk_32f cycle. Whenever no word is pending at a slot boundary, the
//   IDLE_WORD comma is sent instead. After reset, SYNC_WORDS idle words are
//   sent before any input is accepted.
//
// Ports
//   clk_32f     in   serial bit clock, rising edge
//   reset       in   asynchronous active-low reset
//   valid_in    in   Data_in holds a word to send
//   Data_in     in   [WIDTH-1:0] parallel word
//   ready_out   out  block accepts a word this cycle (decoded from registers)
//   Data_out    out  serial bit, registered
//   active_out  out  registered, 1 while Data_out carries a data-word bit
//   word_start  out  registered, 1 on the first bit of every word slot
//
// Handshake: a word transfers on a rising edge where valid_in && ready_out.
// While ready_out is low, valid_in is ignored and the source must hold
// Data_in stable until ready_out is high.
module parallel_serial_gen #(
  parameter int unsigned             WIDTH      = 8,
  parameter logic [WIDTH-1:0]        IDLE_WORD  = 8'hBC,
  parameter bit                      MSB_FIRST  = 1'b1,
  parameter int unsigned             SYNC_WORDS = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] Data_in,
  output logic             ready_out,
  output logic             Data_out,
  output logic             active_out,
  output logic             word_start
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned SW = $clog2(SYNC_WORDS + 1);

  typedef enum logic {
    S_SYNC = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] cur;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] buf_q;
  logic             buf_full;
  logic             cur_is_data;
  logic [SW-1:0]    sync_cnt;

  logic             boundary;
  logic             sync_done;
  logic             take;
  logic             load_data;
  logic [CW-1:0]    idx;

  // The edge that finishes the last bit of a slot also reloads cur.
  assign boundary  = (cnt == CW'(WIDTH - 1));
  // Compared against the post-increment value: the boundary that completes
  // idle word SYNC_WORDS-1 switches to RUN, so the word it loads is the last
  // preamble word.
  assign sync_done = ((sync_cnt + SW'(1)) == SW'(SYNC_WORDS));
  assign take      = valid_in && ready_out;
  // Uses the buffer flag before the edge: a word taken on the boundary edge
  // itself waits for the next slot.
  assign load_data = boundary && (state == S_RUN) && buf_full;

  always_comb begin
    idx = cnt;
    if (MSB_FIRST) idx = CW'(WIDTH - 1) - cnt;
  end

  // FSM: state register
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) state <= S_SYNC;
    else        state <= state_nxt;
  end

  // FSM: next state (RUN is absorbing until reset)
  always_comb begin
    state_nxt = state;
    if ((state == S_SYNC) && boundary && sync_done) state_nxt = S_RUN;
  end

  // FSM: outputs
  always_comb begin
    ready_out = 1'b0;
    if ((state == S_RUN) && !buf_full) ready_out = 1'b1;
  end

  // Shifter, slot sequencing, hold buffer and preamble counter
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      Data_out    <= 1'b0;
      active_out  <= 1'b0;
      word_start  <= 1'b0;
      cnt         <= '0;
      cur         <= IDLE_WORD;
      cur_is_data <= 1'b0;
      buf_q       <= '0;
      buf_full    <= 1'b0;
      sync_cnt    <= SW'(1);
    end else begin
      Data_out   <= cur[idx];
      word_start <= (cnt == '0);
      active_out <= cur_is_data;
      cnt        <= boundary ? '0 : cnt + CW'(1);

      if (boundary) begin
        if (load_data) begin
          cur         <= buf_q;
          cur_is_data <= 1'b1;
          buf_full    <= 1'b0;
        end else begin
          cur         <= IDLE_WORD;
          cur_is_data <= 1'b0;
        end
        if (state == S_SYNC) sync_cnt <= sync_cnt + SW'(1);
      end

      // take needs !buf_full and load_data needs buf_full, so they never
      // coincide.
      if (take) begin
        buf_q    <= Data_in;
        buf_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parallel_serial_gen.sv
module tb_parallel_serial_gen;

  // ---------------- clock / reset ----------------
  logic clk_32f = 1'b0;
  logic reset   = 1'b0;
  always #5 clk_32f = ~clk_32f;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  // DUT a: defaults. DUT b: LSB first. DUT c: WIDTH=10, SYNC_WORDS=2.
  logic       v_a = 1'b0, v_b = 1'b0, v_c = 1'b0;
  logic [7:0] d_a = '0, d_b = '0;
  logic [9:0] d_c = '0;
  logic       r_a, o_a, act_a, ws_a;
  logic       r_b, o_b, act_b, ws_b;
  logic       r_c, o_c, act_c, ws_c;

  parallel_serial_gen u_a (
    .clk_32f(clk_32f), .reset(reset), .valid_in(v_a), .Data_in(d_a),
    .ready_out(r_a), .Data_out(o_a), .active_out(act_a), .word_start(ws_a));

  parallel_serial_gen #(.WIDTH(8), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b0), .SYNC_WORDS(4)) u_b (
    .clk_32f(clk_32f), .reset(reset), .valid_in(v_b), .Data_in(d_b),
    .ready_out(r_b), .Data_out(o_b), .active_out(act_b), .word_start(ws_b));

  parallel_serial_gen #(.WIDTH(10), .IDLE_WORD(10'h17C), .MSB_FIRST(1'b1), .SYNC_WORDS(2)) u_c (
    .clk_32f(clk_32f), .reset(reset), .valid_in(v_c), .Data_in(d_c),
    .ready_out(r_c), .Data_out(o_c), .active_out(act_c), .word_start(ws_c));

  // Hand-written serial sequences, element 0 = first bit on the wire.
  logic [0:7]  seq_idle_msb = 8'b1011_1100;
  logic [0:7]  seq_idle_lsb = 8'b0011_1101;
  logic [0:9]  seq_idle_w10 = 10'b01_0111_1100;
  logic [0:7]  seq_5a       = 8'b0101_1010;
  logic [0:7]  seq_0f_lsb   = 8'b1111_0000;
  logic [0:23] seq_b2b      = 24'b00000001_10000000_11111111;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_32f);
    #1;
    edge_n++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    #1;
    if ({o_a, act_a, ws_a, r_a} !== 4'b0000) begin
      bad++; $display("FAIL reset_a got=%b exp=0000", {o_a, act_a, ws_a, r_a});
    end
    total++;
    if ({o_b, act_b, ws_b, r_b} !== 4'b0000) begin
      bad++; $display("FAIL reset_b got=%b exp=0000", {o_b, act_b, ws_b, r_b});
    end
    total++;
    if ({o_c, act_c, ws_c, r_c} !== 4'b0000) begin
      bad++; $display("FAIL reset_c got=%b exp=0000", {o_c, act_c, ws_c, r_c});
    end
    total++;
    repeat (3) @(posedge clk_32f);
    #1;
    reset  = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_sync();
    for (int e = 1; e <= 24; e++) begin
      tick();
      if (o_a !== seq_idle_msb[(e-1)%8]) begin
        bad++; $display("FAIL sync_a_bit edge=%0d got=%b exp=%b", e, o_a, seq_idle_msb[(e-1)%8]);
      end
      total++;
      if (act_a !== 1'b0) begin
        bad++; $display("FAIL sync_a_active edge=%0d got=%b exp=0", e, act_a);
      end
      total++;
      if (ws_a !== ((e-1)%8 == 0)) begin
        bad++; $display("FAIL sync_a_ws edge=%0d got=%b exp=%b", e, ws_a, ((e-1)%8 == 0));
      end
      total++;
      if (r_a !== (e >= 24)) begin
        bad++; $display("FAIL sync_a_ready edge=%0d got=%b exp=%b", e, r_a, (e >= 24));
      end
      total++;
      if (o_b !== seq_idle_lsb[(e-1)%8]) begin
        bad++; $display("FAIL sync_b_bit edge=%0d got=%b exp=%b", e, o_b, seq_idle_lsb[(e-1)%8]);
      end
      total++;
      if (r_b !== (e >= 24)) begin
        bad++; $display("FAIL sync_b_ready edge=%0d got=%b exp=%b", e, r_b, (e >= 24));
      end
      total++;
      if (o_c !== seq_idle_w10[(e-1)%10]) begin
        bad++; $display("FAIL w10_bit edge=%0d got=%b exp=%b", e, o_c, seq_idle_w10[(e-1)%10]);
      end
      total++;
      if (ws_c !== ((e-1)%10 == 0)) begin
        bad++; $display("FAIL w10_ws edge=%0d got=%b exp=%b", e, ws_c, ((e-1)%10 == 0));
      end
      total++;
      if (r_c !== (e >= 10)) begin
        bad++; $display("FAIL w10_ready edge=%0d got=%b exp=%b", e, r_c, (e >= 10));
      end
      total++;
    end
  endtask

  task automatic test_single_word();
    v_a = 1'b1; d_a = 8'h5A;
    v_b = 1'b1; d_b = 8'h0F;
    tick(); // edge 25: both words accepted
    if (r_a !== 1'b0) begin
      bad++; $display("FAIL single_a_ready_full got=%b exp=0", r_a);
    end
    total++;
    if (r_b !== 1'b0) begin
      bad++; $display("FAIL single_b_ready_full got=%b exp=0", r_b);
    end
    total++;
    v_a = 1'b0; v_b = 1'b0;
    for (int e = 26; e <= 32; e++) tick();
    if (r_a !== 1'b1) begin
      bad++; $display("FAIL single_a_ready_after_boundary got=%b exp=1", r_a);
    end
    total++;
    for (int e = 33; e <= 48; e++) begin
      tick();
      if (e <= 40) begin
        if ({o_a, act_a} !== {seq_5a[e-33], 1'b1}) begin
          bad++; $display("FAIL single_a_data edge=%0d got=%b exp=%b", e, {o_a, act_a}, {seq_5a[e-33], 1'b1});
        end
        total++;
        if ({o_b, act_b} !== {seq_0f_lsb[e-33], 1'b1}) begin
          bad++; $display("FAIL single_b_data edge=%0d got=%b exp=%b", e, {o_b, act_b}, {seq_0f_lsb[e-33], 1'b1});
        end
        total++;
      end else begin
        if ({o_a, act_a} !== {seq_idle_msb[e-41], 1'b0}) begin
          bad++; $display("FAIL single_a_idle edge=%0d got=%b exp=%b", e, {o_a, act_a}, {seq_idle_msb[e-41], 1'b0});
        end
        total++;
        if ({o_b, act_b} !== {seq_idle_lsb[e-41], 1'b0}) begin
          bad++; $display("FAIL single_b_idle edge=%0d got=%b exp=%b", e, {o_b, act_b}, {seq_idle_lsb[e-41], 1'b0});
        end
        total++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    int         idx;
    logic       rdy;
    logic       exp_r;
    words = '{8'h01, 8'h80, 8'hFF};
    idx = 0;
    for (int e = 49; e <= 88; e++) begin
      v_a = (idx < 3);
      d_a = (idx < 3) ? words[idx] : 8'h00;
      rdy = r_a;
      tick();
      if (v_a && rdy) idx++;
      exp_r = (e >= 72) || (e == 56) || (e == 64);
      if (r_a !== exp_r) begin
        bad++; $display("FAIL b2b_ready edge=%0d got=%b exp=%b", e, r_a, exp_r);
      end
      total++;
      if (e >= 57 && e <= 80) begin
        if ({o_a, act_a} !== {seq_b2b[e-57], 1'b1}) begin
          bad++; $display("FAIL b2b_data edge=%0d got=%b exp=%b", e, {o_a, act_a}, {seq_b2b[e-57], 1'b1});
        end
        total++;
      end else begin
        if ({o_a, act_a} !== {seq_idle_msb[(e-49)%8], 1'b0}) begin
          bad++; $display("FAIL b2b_idle edge=%0d got=%b exp=%b", e, {o_a, act_a}, {seq_idle_msb[(e-49)%8], 1'b0});
        end
        total++;
      end
    end
    v_a = 1'b0;
  endtask

  task automatic test_mid_reset();
    v_a = 1'b1; d_a = 8'hA5;
    tick(); // edge 89: A5 accepted
    v_a = 1'b0;
    for (int e = 90; e <= 96; e++) tick();
    v_a = 1'b1; d_a = 8'h3C;
    tick(); // edge 97: first bit of A5 out, 3C accepted mid-slot
    v_a = 1'b0;
    if ({o_a, act_a, ws_a, r_a} !== 4'b1110) begin
      bad++; $display("FAIL midrst_before got=%b exp=1110", {o_a, act_a, ws_a, r_a});
    end
    total++;
    #1;
    reset = 1'b0;
    #1;
    if ({o_a, act_a, ws_a, r_a} !== 4'b0000) begin
      bad++; $display("FAIL midrst_immediate got=%b exp=0000", {o_a, act_a, ws_a, r_a});
    end
    total++;
    repeat (3) @(posedge clk_32f);
    #1;
    reset  = 1'b1;
    edge_n = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if ({o_a, act_a} !== {seq_idle_msb[(e-1)%8], 1'b0}) begin
        bad++; $display("FAIL midrst_idle edge=%0d got=%b exp=%b", e, {o_a, act_a}, {seq_idle_msb[(e-1)%8], 1'b0});
      end
      total++;
      if (r_a !== (e >= 24)) begin
        bad++; $display("FAIL midrst_ready edge=%0d got=%b exp=%b", e, r_a, (e >= 24));
      end
      total++;
      if (ws_a !== ((e-1)%8 == 0)) begin
        bad++; $display("FAIL midrst_ws edge=%0d got=%b exp=%b", e, ws_a, ((e-1)%8 == 0));
      end
      total++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_sync();
    test_single_word();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parallel_serial_gen.md
# parallel_serial_gen

Parametrised PHY-TX serializer. It converts WIDTH-bit parallel words to a bit-serial stream on `clk_32f`, one bit per cycle, and transmits a configurable idle/comma word whenever no data is pending. It adds four things to the fixed 8-bit serializer:
- a valid/ready input handshake with a one-word holding buffer;
- a post-reset sync preamble of SYNC_WORDS idle words;
- a selectable bit order;
- word-framing and data-qualifier outputs for the downstream lane logic.

## Interface
Parameters:
- WIDTH, 8, word width in bits. Must be ≥ 2.
- IDLE_WORD, 8'hBC, WIDTH-bit word sent when no data is pending.
- MSB_FIRST, 1, selects bit order: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
- SYNC_WORDS, 4, number of idle words sent after reset before input is accepted. Must be ≥ 2.

Ports:
- clk_32f  in  1  serial bit clock. All state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  Data_in holds a word to send.
- Data_in  in  WIDTH  parallel word.
- ready_out  out  1  block accepts a word this cycle. Combinational from registers only.
- Data_out  out  1  serial bit, registered.
- active_out  out  1  registered; 1 while Data_out carries a bit of a data word, 0 for idle words.
- word_start  out  1  registered; 1 on the first bit of every word slot.

## Operation
- Registers:
  - cur: word currently being shifted out.
  - bit counter cnt: 0..WIDTH-1.
  - hold buffer buf, with flag buf_full.
  - cur_is_data flag.
  - state: SYNC or RUN.
  - sync_cnt.
- Reset values (applied immediately while reset=0):
  - Data_out=0, active_out=0, word_start=0, ready_out=0.
  - cnt=0, cur=IDLE_WORD, cur_is_data=0.
  - buf_full=0, buf contents discarded.
  - state=SYNC, sync_cnt=1.
- Every edge:
  - Data_out ← cur[idx], where idx = WIDTH-1-cnt if MSB_FIRST=1, else idx = cnt.
  - word_start ← (cnt==0).
  - active_out ← cur_is_data.
  - cnt ← cnt+1, wrapping from WIDTH-1 to 0.
- Handshake:
  - ready_out = (state==RUN) && !buf_full.
  - A transfer occurs on an edge where valid_in && ready_out. On that edge buf ← Data_in and buf_full ← 1.
  - valid_in while ready_out=0 is ignored. The source must hold the word until ready_out=1.
- Slot boundary (edge with cnt==WIDTH-1 before the edge):
  - If state==RUN and buf_full: cur ← buf, cur_is_data ← 1, buf_full ← 0.
  - Otherwise: cur ← IDLE_WORD, cur_is_data ← 0.
  - The decision uses pre-edge buf_full. A word accepted on the boundary edge itself waits for the next boundary. There is no bypass.
- SYNC state:
  - ready_out=0.
  - At each boundary, sync_cnt ← sync_cnt+1.
  - At the boundary where sync_cnt+1 == SYNC_WORDS: state ← RUN. That boundary still loads IDLE_WORD.
- RUN state is absorbing until reset.
- Reset mid-word: output stops immediately, the buffered word is lost, and the full SYNC preamble repeats.

## Timing
- Edges are counted from the first rising edge after reset release, which is edge 1.
- Word k (k≥1) is driven on edges 8(k-1)+1 .. 8k (for WIDTH=8). word_start is high after edges 1, 9, 17, ...
- For the defaults, ready_out rises after edge 24 (the boundary that loads idle word #4).
- Latency: a word accepted during slot n is driven starting at the first edge of slot n+1. Worst-case latency from accept to first bit is WIDTH+1 edges; best case is 2 edges (accept on the last in-slot edge before the boundary).
- Throughput: one word per WIDTH cycles.
  - ready_out returns high on the edge after each boundary that consumes buf. The source then has WIDTH-1 edges to refill before the next boundary.
  - Sustained valid_in therefore gives gapless data.
- Idle insertion happens only if buf is empty at a boundary. There are never partial words.

## Test plan
- Reset, then release with valid_in=0 (defaults) -> Data_out repeats 1,0,1,1,1,1,0,0 from edge 1. active_out=0 throughout. word_start pulses every 8 edges. ready_out=0 through edge 24 and 1 afterwards.
- valid_in=1, Data_in=8'h5A presented from edge 25 -> accepted at edge 25. Edges 33-40 drive 0,1,0,1,1,0,1,0 with active_out=1. Edges 41-48 drive idle 8'hBC.
- Back-to-back 8'h01, 8'h80, 8'hFF with valid_in held -> 24 consecutive data bits 00000001 10000000 11111111. No idle word between them. ready_out low on each edge where buf is full.
- MSB_FIRST=0, Data_in=8'h0F after sync -> data slot is 1,1,1,1,0,0,0,0. Idle slots are 0,0,1,1,1,1,0,1.
- Word accepted mid-slot, then reset pulsed low for 3 cycles before the boundary -> Data_out, active_out and word_start are 0 immediately. The accepted word never appears. After release, exactly 4 idle words are sent before ready_out=1.
- WIDTH=10, IDLE_WORD=10'h17C, SYNC_WORDS=2 -> idle pattern 0101111100 with a 10-edge word period. ready_out rises after edge 10.
